// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial ripple adder. One full-add bit-slice per clock,
//                LSB first, carry held in a flop. Publishes Sum/Cout with a
//                one-cycle Done strobe after WIDTH shift cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8            // operand/sum width, legal 2..32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    // Counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
    localparam int               c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_sr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_carry;

    logic               w_s;
    logic               w_carry_nxt;

    // Single shared full-add cell operating on the current LSBs and carry.
    assign w_s         = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_carry_nxt = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);

    // Control FSM plus datapath; outputs are registered and only the
    // completion edge may update Sum/Cout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_SHIFT: begin
                    r_carry <= w_carry_nxt;
                    r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
                    r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
                    r_sr    <= {w_s, r_sr[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_BIT) begin
                        // Include the bit being processed on this very edge.
                        Sum     <= {w_s, r_sr[WIDTH-1:1]};
                        Cout    <= w_carry_nxt;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                // IDLE and DONE accept Start identically, giving back-to-back
                // operation without an idle gap.
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_opa   <= A;
                        r_opb   <= B;
                        r_carry <= Cin;
                        r_cnt   <= '0;
                        Busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8): vector table,
//                corner-case sequences and randomized operations against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    int n_checks = 0;
    int n_fail   = 0;

    int done_cnt   = 0;
    int accept_cnt = 0;
    bit overlap    = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tallies Done strobes and flags any Busy/Done overlap.
    always @(negedge clk) begin
        if (!rst) begin
            if (Done) done_cnt++;
            if (Done && Busy) overlap = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain unsigned arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    // Issue one Start in the coming cycle and release it after acceptance;
    // operand inputs are then scrambled to prove they are not resampled.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        @(negedge clk);
        Start = 1'b1; A = a; B = b; Cin = c;
        @(posedge clk);
        #1;
        Start = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom);
        accept_cnt++;
    endtask

    // Wait for Done with a bounded budget; reports busy cycles and Sum stability.
    task automatic wait_done(input logic [WIDTH-1:0] prev, output bit seen,
                             output int busy_n, output bit hold_ok);
        seen = 1'b0; busy_n = 0; hold_ok = 1'b1;
        for (int i = 0; i < 3 * WIDTH && !seen; i++) begin
            @(negedge clk);
            if (Done) seen = 1'b1;
            else begin
                if (Busy) busy_n++;
                if (Sum !== prev || Cout !== 1'b0 && prev === 'x) hold_ok = 1'b0;
            end
        end
    endtask

    // Full single operation with latency, strobe-width and hold checks.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic [WIDTH-1:0] es, input logic ec);
        logic [WIDTH-1:0] prev;
        bit seen; int busy_n; bit hold_ok;
        prev = Sum;
        issue(a, b, c);
        wait_done(prev, seen, busy_n, hold_ok);
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(WIDTH));
        chk({tag, " sum"}, 32'(Sum), 32'(es));
        chk({tag, " cout"}, 32'(Cout), 32'(ec));
        chk({tag, " sum_hold"}, 32'(hold_ok), 32'd1);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(Done), 32'd0);
    endtask

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        logic [WIDTH-1:0] es;
        logic             ec;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit seen; int busy_n; bit hold_ok; int cnt;
        logic [WIDTH:0] ref_v;
        logic [WIDTH-1:0] ra, rb; logic rc;

        vecs[0] = '{"basic",      8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{"ripple",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{"all_ones",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{"zero",       8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{"cin_only",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{"msb_carry",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{"to_msb",     8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset sum",  32'(Sum),  32'd0);
        chk("reset cout", 32'(Cout), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 7; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].es, vecs[i].ec);

        // Start while busy is ignored; only one Done, operands not resampled.
        issue(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        Start = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("ignore sum_held", 32'(Sum), 32'h80);
        wait_done(Sum, seen, busy_n, hold_ok);
        chk("ignore done_seen", 32'(seen), 32'd1);
        chk("ignore sum", 32'(Sum), 32'h30);
        chk("ignore cout", 32'(Cout), 32'd0);
        cnt = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (Done) cnt++;
        end
        chk("ignore extra_done", 32'(cnt), 32'd0);

        // Back-to-back: Start in the Done cycle.
        issue(8'h01, 8'h02, 1'b0);
        wait_done(Sum, seen, busy_n, hold_ok);
        chk("b2b first_done", 32'(seen), 32'd1);
        chk("b2b first_sum", 32'(Sum), 32'h03);
        Start = 1'b1; A = 8'h80; B = 8'h80; Cin = 1'b0;
        @(posedge clk);
        #1;
        Start = 1'b0; A = 8'h11; B = 8'h22;
        accept_cnt++;
        chk("b2b busy_reassert", 32'(Busy), 32'd1);
        chk("b2b no_overlap", 32'(Done), 32'd0);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 3 * WIDTH && !seen; i++) begin
            @(negedge clk);
            cnt++;
            if (Done) seen = 1'b1;
        end
        chk("b2b spacing", 32'(cnt), 32'(WIDTH + 1));
        chk("b2b sum", 32'(Sum), 32'h00);
        chk("b2b cout", 32'(Cout), 32'd1);
        @(negedge clk);

        // Asynchronous reset mid-operation.
        issue(8'h33, 8'h44, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst busy", 32'(Busy), 32'd0);
        chk("async_rst done", 32'(Done), 32'd0);
        chk("async_rst sum",  32'(Sum),  32'd0);
        chk("async_rst cout", 32'(Cout), 32'd1 - 32'd1);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (Done || Busy) cnt++;
        end
        chk("async_rst no_activity", 32'(cnt), 32'd0);
        chk("async_rst sum_stays", 32'(Sum), 32'd0);

        // Randomized operations against the reference model.
        done_cnt = 0; accept_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
            if (n == 0) begin ra = '1; rb = '1; rc = 1'b1; end
            ref_v = model(ra, rb, rc);
            issue(ra, rb, rc);
            wait_done(Sum, seen, busy_n, hold_ok);
            chk("rand done_seen", 32'(seen), 32'd1);
            chk("rand sum_cout", 32'({Cout, Sum}), 32'(ref_v));
            if ($urandom_range(0, 3) != 0) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("rand done_vs_accept", 32'(done_cnt), 32'(accept_cnt));
        chk("busy_done_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
